// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - host command FIFO and paced issue stage for the LCD controller
// Buffers host commands, issues them as one-cycle strobes while the controller is idle, then waits for write-back done.
module lcd_cmd_sequencer #(
  parameter int DEPTH = 8,
  parameter int GAP   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] in_cmd,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       busy,
  input  logic       done,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  output logic [7:0] issued_cnt,
  output logic       seq_done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] GAP_L = 3'(GAP);

  typedef enum logic [1:0] {WAIT_INIT, ISSUE, DRAIN, FIN} state_t;

  state_t      state, state_nxt;
  logic [2:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [2:0]  gap_cnt;
  logic        wb_taken;
  logic        empty, full, push, issue, gap_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Gated by reset so the port reads 0 while reset is held.
  assign in_ready = reset && !full && !wb_taken && (state != FIN);
  assign push     = in_valid && in_ready;

  // The idle cycle being decided on counts toward the gap, giving a GAP+1 issue period.
  assign gap_ok = (gap_cnt == 3'd0) || ((gap_cnt == 3'd1) && !cmd_valid);

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      WAIT_INIT: if (!busy) state_nxt = ISSUE;
      ISSUE: begin
        issue = !empty && !busy && gap_ok && !cmd_valid;
        // Leave once the write-back strobe has completed so cmd_valid is never high in DRAIN.
        if (cmd_valid && (cmd == 3'd0)) state_nxt = DRAIN;
      end
      DRAIN: if (done) state_nxt = FIN;
      FIN:   state_nxt = FIN;
      default: state_nxt = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= WAIT_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_cmd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wb_taken <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (in_cmd == 3'd0) wb_taken <= 1'b1;
      end
      if (issue) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd        <= 3'd0;
      cmd_valid  <= 1'b0;
      issued_cnt <= 8'd0;
      gap_cnt    <= 3'd0;
      seq_done   <= 1'b0;
    end else begin
      cmd_valid <= issue;
      if (issue) begin
        cmd     <= mem[rd_ptr[AW-1:0]];
        gap_cnt <= GAP_L;
        if (issued_cnt != 8'hFF) issued_cnt <= issued_cnt + 8'd1;
      end else if (!cmd_valid && (gap_cnt != 3'd0)) begin
        gap_cnt <= gap_cnt - 3'd1;
      end
      if ((state == DRAIN) && done) seq_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - directed self-checking bench for lcd_cmd_sequencer
module tb_lcd_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] in_cmd;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] issued_cnt;
  logic       seq_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  int pushed;
  logic [2:0] pulse_c[$];
  int         pulse_t[$];
  int         exp_q[$];

  lcd_cmd_sequencer #(.DEPTH(8), .GAP(1)) dut (
    .clk(clk), .reset(reset), .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
    .issued_cnt(issued_cnt), .seq_done(seq_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      pulse_c.push_back(cmd);
      pulse_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c);
    in_valid = 1'b1;
    in_cmd   = c;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic clear_pulses();
    pulse_c.delete();
    pulse_t.delete();
  endtask

  // Compares recorded strobes against exp_q: codes, first edge and spacing.
  task automatic check_pulses(input string tag, input int first_t, input int spacing);
    check({tag, "_count"}, pulse_c.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < pulse_c.size()) begin
        check($sformatf("%s_code%0d", tag, i), pulse_c[i], exp_q[i]);
        check($sformatf("%s_time%0d", tag, i), pulse_t[i], first_t + i * spacing);
      end
    end
  endtask

  task automatic async_reset(input string tag);
    #3 reset = 1'b0;
    #1;
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_seq_done"}, seq_done, 0);
    check({tag, "_issued"}, issued_cnt, 0);
    check({tag, "_in_ready"}, in_ready, 0);
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; busy = 1'b1; done = 1'b0; in_valid = 1'b0; in_cmd = 3'd0;
    #3;
    check("rst_cmd", cmd, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_issued", issued_cnt, 0);
    check("rst_seq_done", seq_done, 0);
    step(2);
    reset = 1'b1;
    #1 check("post_rst_in_ready", in_ready, 1);

    // Startup: busy held 70 cycles with 1,4,5 queued.
    push(3'd1); push(3'd4); push(3'd5);
    step(67);
    check("startup_no_pulse", pulse_c.size(), 0);
    busy = 1'b0; t0 = cyc;
    step(10);
    exp_q = '{1, 4, 5};
    check_pulses("startup", t0 + 2, 2);
    check("startup_issued", issued_cnt, 3);

    // Full FIFO.
    busy = 1'b1; clear_pulses();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_ready%0d", i), in_ready, 1);
      push(3'(i % 7 + 1));
    end
    check("full_ready_drop", in_ready, 0);
    push(3'd2);
    check("full_ready_still0", in_ready, 0);
    busy = 1'b0; t0 = cyc;
    step(20);
    exp_q = '{1, 2, 3, 4, 5, 6, 7, 1};
    check_pulses("full", t0 + 1, 2);
    check("full_issued", issued_cnt, 11);

    // Busy for 5 cycles between two issues.
    busy = 1'b1; clear_pulses();
    push(3'd6); push(3'd3);
    busy = 1'b0; t0 = cyc;
    step(1);
    busy = 1'b1;
    step(5);
    busy = 1'b0;
    step(8);
    exp_q = '{6, 3};
    check_pulses("midbusy", t0 + 1, 6);
    check("midbusy_issued", issued_cnt, 13);

    // Push and pop on the same edge with one entry held.
    busy = 1'b1; clear_pulses();
    push(3'd7);
    busy = 1'b0; in_valid = 1'b1; in_cmd = 3'd2; t0 = cyc;
    step(1);
    in_valid = 1'b0;
    step(10);
    exp_q = '{7, 2};
    check_pulses("pushpop", t0 + 1, 2);
    check("pushpop_issued", issued_cnt, 15);

    // Saturation of issued_cnt.
    clear_pulses(); pushed = 0;
    for (int k = 0; k < 1200; k++) begin
      if (pushed < 250) begin
        in_valid = 1'b1; in_cmd = 3'd1;
        if (in_ready) pushed++;
      end else begin
        in_valid = 1'b0;
      end
      step(1);
    end
    in_valid = 1'b0;
    check("sat_pulses", pulse_c.size(), 250);
    check("sat_issued", issued_cnt, 255);

    // Write-back from a fresh start.
    async_reset("rst_a");
    busy = 1'b1; clear_pulses();
    push(3'd2); push(3'd6); push(3'd0);
    check("wb_ready_low", in_ready, 0);
    push(3'd3);
    busy = 1'b0; t0 = cyc;
    step(12);
    exp_q = '{2, 6, 0};
    check_pulses("wb", t0 + 2, 2);
    check("wb_issued", issued_cnt, 3);
    check("wb_no_done_yet", seq_done, 0);
    done = 1'b1;
    #1 check("wb_done_before_edge", seq_done, 0);
    step(1);
    check("wb_seq_done", seq_done, 1);
    done = 1'b0;
    step(4);
    check("wb_seq_done_sticky", seq_done, 1);
    check("wb_no_more_pulses", pulse_c.size(), 3);
    check("wb_ready_fin", in_ready, 0);

    // Asynchronous reset while in DRAIN.
    async_reset("rst_b");
    busy = 1'b1;
    push(3'd0);
    busy = 1'b0;
    step(6);
    check("drain_issued", issued_cnt, 1);
    check("drain_seq_done", seq_done, 0);
    busy = 1'b1;
    async_reset("rst_drain");
    clear_pulses();
    push(3'd3);
    step(10);
    check("rerun_wait_busy", pulse_c.size(), 0);
    busy = 1'b0; t0 = cyc;
    step(6);
    exp_q = '{3};
    check_pulses("rerun", t0 + 2, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
